mem_port_arbiter: RTL

Two-requester arbiter that shares the single-port 32-bit main memory between the CPU instruction-fetch path and the data-memory path. It sits between the CPU (fetch and data-access sides) and main memory. It latches each granted request, sequences exactly one memory transaction at a time, and returns per-side BUSYWAIT stalls and read data. Round-robin fairness prevents either side from starving the other. A watchdog flags memory transactions that never complete.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 32-bit main memory between the
// instruction-fetch side (I) and the data side (D). One transaction at a
// time, round-robin on ties, sticky watchdog on transactions that never end.
//
// Requester handshake: a side raises its request (I_READ, or D_READ/D_WRITE)
// with address/data stable and holds it while x_BUSYWAIT is high; the cycle
// x_BUSYWAIT is seen low with the request high is the completion cycle, and
// the requester must drop or change its request at the following rising edge.
// Memory handshake: MEM_READ/MEM_WRITE are held with MEM_ADDRESS and
// MEM_WRITEDATA stable until a rising edge samples MEM_BUSYWAIT low.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ,
  input  logic [5:0]  I_ADDRESS,
  output logic [31:0] I_READDATA,
  output logic        I_BUSYWAIT,
  input  logic        D_READ,
  input  logic        D_WRITE,
  input  logic [5:0]  D_ADDRESS,
  input  logic [31:0] D_WRITEDATA,
  output logic [31:0] D_READDATA,
  output logic        D_BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic        ERROR,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_I   = 3'd1,
    GRANT_D   = 3'd2,
    RELEASE_I = 3'd3,
    RELEASE_D = 3'd4
  } state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic       grant_i;
  logic       grant_d;
  logic       in_grant;
  logic       done;
  logic       d_req;
  logic       last_grant_d;  // 0: I was granted last (so D wins the next tie)
  logic       op_write;
  logic [9:0] wd_cnt;

  assign d_req    = D_READ | D_WRITE;
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign done     = in_grant && !MEM_BUSYWAIT;

  // Strobes decode straight from state so an async reset drops them at once.
  assign MEM_READ   = in_grant && !op_write;
  assign MEM_WRITE  = in_grant && op_write;
  assign I_BUSYWAIT = I_READ && (state != RELEASE_I);
  assign D_BUSYWAIT = d_req && (state != RELEASE_D);
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and grant decision; round-robin on simultaneous requests.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (I_READ && d_req) begin
          grant_d = !last_grant_d;
          grant_i = last_grant_d;
        end else begin
          grant_d = d_req;
          grant_i = I_READ;
        end
        if (grant_d)      state_nxt = GRANT_D;
        else if (grant_i) state_nxt = GRANT_I;
      end
      GRANT_I:   if (!MEM_BUSYWAIT) state_nxt = RELEASE_I;
      GRANT_D:   if (!MEM_BUSYWAIT) state_nxt = RELEASE_D;
      RELEASE_I: state_nxt = IDLE;
      RELEASE_D: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Latch the granted request; requester inputs are ignored afterwards.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_ADDRESS   <= 6'd0;
      MEM_WRITEDATA <= 32'd0;
      op_write      <= 1'b0;
      last_grant_d  <= 1'b0;
    end else if (grant_i || grant_d) begin
      MEM_ADDRESS  <= grant_d ? D_ADDRESS : I_ADDRESS;
      if (grant_d) MEM_WRITEDATA <= D_WRITEDATA;
      op_write     <= grant_d && D_WRITE;
      last_grant_d <= grant_d;
    end
  end

  // Capture read data on completion; held until the same side's next read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      I_READDATA <= 32'd0;
      D_READDATA <= 32'd0;
    end else if (done && !op_write) begin
      if (state == GRANT_I) I_READDATA <= MEM_READDATA;
      else                  D_READDATA <= MEM_READDATA;
    end
  end

  // Watchdog: count busy GRANT cycles; completion at TIMEOUT-1 never flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= 10'd0;
      ERROR  <= 1'b0;
    end else if (grant_i || grant_d) begin
      wd_cnt <= 10'd0;
    end else if (in_grant && MEM_BUSYWAIT) begin
      if (wd_cnt != 10'h3FF) wd_cnt <= wd_cnt + 10'd1;
      if (wd_cnt + 10'd1 == TIMEOUT_CNT) ERROR <= 1'b1;
    end
  end

endmodule
